// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants, ALU control codes and request kinds.
package rv_enc_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Same codes the core's ALU decode produces.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        KIND_R_ALU = 3'd0,
        KIND_I_ALU = 3'd1,
        KIND_LW    = 3'd2,
        KIND_SW    = 3'd3,
        KIND_BEQ   = 3'd4,
        KIND_LUI   = 3'd5,
        KIND_JAL   = 3'd6,
        KIND_RSVD  = 3'd7
    } req_kind_e;

    // Returns {code_ok, funct3} for an ALU control code.
    function automatic logic [3:0] alu_decode(input logic [2:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB: return {1'b1, F3_ADD_SUB};
            ALU_AND:          return {1'b1, F3_AND};
            ALU_OR:           return {1'b1, F3_OR};
            ALU_SLT:          return {1'b1, F3_SLT};
            default:          return {1'b0, 3'b000};
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Scatters an immediate into its instruction-word bit positions per kind.
// Range checking is present only when RV_ENC_IMM_CHECK_EN is defined.
module rv_imm_pack
    import rv_enc_pkg::*;
(
    input  req_kind_e   kind,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    always_comb begin
        imm_bits = '0;
        case (kind)
            KIND_I_ALU, KIND_LW: imm_bits[31:20] = imm[11:0];
            KIND_SW: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
            end
            KIND_BEQ: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
            end
            KIND_LUI: imm_bits[31:12] = imm[31:12];
            KIND_JAL: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
            end
            default: ;
        endcase
    end

`ifdef RV_ENC_IMM_CHECK_EN
    // Upper bits must be a pure sign extension of the encodable field.
    always_comb begin
        range_ok = 1'b1;
        case (kind)
            KIND_I_ALU, KIND_LW, KIND_SW: range_ok = (imm[31:11] == {21{imm[11]}});
            KIND_BEQ: range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            KIND_JAL: range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            KIND_LUI: range_ok = (imm[11:0] == 12'h000);
            default:  range_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm;
    assign unused_imm = imm[0];
    assign range_ok   = 1'b1;
`endif

endmodule

// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder: request handshake in, one registered word out.
// Optional immediate range checking via RV_ENC_IMM_CHECK_EN (in rv_imm_pack).
module rv_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_kind_i,
    input  logic [2:0]        req_alu_ctrl_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [31:0]       req_imm_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [15:0]       inst_count_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    req_kind_e   kind;
    logic [31:0] imm_bits;
    logic        imm_ok;
    logic [3:0]  alu_dec;
    logic        alu_ok;
    logic [2:0]  alu_f3;
    logic        is_sub;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        emit;

    assign kind    = req_kind_e'(req_kind_i);
    assign alu_dec = alu_decode(req_alu_ctrl_i);
    assign alu_ok  = alu_dec[3];
    assign alu_f3  = alu_dec[2:0];
    assign is_sub  = (req_alu_ctrl_i == ALU_SUB);

    rv_imm_pack u_imm_pack (
        .kind     (kind),
        .imm      (req_imm_i),
        .imm_bits (imm_bits),
        .range_ok (imm_ok)
    );

    // Register fields an encoding does not use stay zero by construction.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (kind)
            KIND_R_ALU: begin
                enc_word  = {is_sub ? F7_SUB : F7_BASE, req_rs2_i, req_rs1_i, alu_f3, req_rd_i, OP_OP};
                enc_legal = alu_ok;
            end
            KIND_I_ALU: begin
                enc_word  = imm_bits | {12'b0, req_rs1_i, alu_f3, req_rd_i, OP_IMM};
                enc_legal = alu_ok && !is_sub;
            end
            KIND_LW:  enc_word = imm_bits | {12'b0, req_rs1_i, F3_LW, req_rd_i, OP_LOAD};
            KIND_SW:  enc_word = imm_bits | {7'b0, req_rs2_i, req_rs1_i, F3_SW, 5'b0, OP_STORE};
            KIND_BEQ: enc_word = imm_bits | {7'b0, req_rs2_i, req_rs1_i, F3_BEQ, 5'b0, OP_BRANCH};
            KIND_LUI: enc_word = imm_bits | {20'b0, req_rd_i, OP_LUI};
            KIND_JAL: enc_word = imm_bits | {20'b0, req_rd_i, OP_JAL};
            default:  enc_legal = 1'b0;
        endcase
        enc_legal = enc_legal && imm_ok;
    end

    assign req_ready_o = !clear_i && (!inst_valid_o || inst_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign emit        = !clear_i && inst_valid_o && inst_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_addr_o  <= BASE;
            inst_count_o <= '0;
            err_o        <= 1'b0;
        end else if (clear_i) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_addr_o  <= BASE;
            inst_count_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (emit) begin
                inst_addr_o <= inst_addr_o + ADDR_W'(4);
                if (inst_count_o != 16'hFFFF)
                    inst_count_o <= inst_count_o + 16'd1;
            end
            // A legal accept replaces the word in the same cycle it is emitted.
            if (accept && enc_legal) begin
                inst_o       <= enc_word;
                inst_valid_o <= 1'b1;
            end else if (emit) begin
                inst_valid_o <= 1'b0;
            end
            if (accept && !enc_legal)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench for rv_inst_encoder: directed encodings plus a randomized scoreboard run.
module tb_rv_inst_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [2:0]  req_alu;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [15:0] inst_count;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_inst_encoder #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_kind_i(req_kind), .req_alu_ctrl_i(req_alu),
        .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_imm_i(req_imm),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_o(inst), .inst_addr_o(inst_addr), .inst_count_o(inst_count), .err_o(err)
    );

`ifdef RV_ENC_IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Reference encoder built from field positions with plain integer arithmetic.
    function automatic void ref_encode(input int kind, input int alu, input longint rd, input longint rs1,
                                       input longint rs2, input logic [31:0] im,
                                       output bit legal, output logic [31:0] word);
        longint v, w, f3;
        bit alu_ok, rng;
        v = longint'($signed(im));
        alu_ok = 1'b1; f3 = 0;
        case (alu)
            0, 1: f3 = 0;
            2: f3 = 7;
            3: f3 = 6;
            5: f3 = 2;
            default: alu_ok = 1'b0;
        endcase
        legal = 1'b1; rng = 1'b1; w = 0;
        case (kind)
            0: begin
                legal = alu_ok;
                w = 'h33 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + ((alu == 1) ? (longint'(32) << 25) : 0);
            end
            1: begin
                legal = alu_ok && alu != 1;
                rng = v >= -2048 && v <= 2047;
                w = 'h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((v & 'hFFF) << 20);
            end
            2: begin
                rng = v >= -2048 && v <= 2047;
                w = 'h03 + (rd << 7) + (2 << 12) + (rs1 << 15) + ((v & 'hFFF) << 20);
            end
            3: begin
                rng = v >= -2048 && v <= 2047;
                w = 'h23 + ((v & 31) << 7) + (2 << 12) + (rs1 << 15) + (rs2 << 20) + (((v >> 5) & 'h7F) << 25);
            end
            4: begin
                rng = v >= -4096 && v <= 4094 && (v & 1) == 0;
                w = 'h63 + (((v >> 11) & 1) << 7) + (((v >> 1) & 15) << 8) + (rs1 << 15) + (rs2 << 20)
                    + (((v >> 5) & 63) << 25) + (((v >> 12) & 1) << 31);
            end
            5: begin
                rng = (v & 'hFFF) == 0;
                w = 'h37 + (rd << 7) + (v & 'hFFFFF000);
            end
            6: begin
                rng = v >= -1048576 && v <= 1048574 && (v & 1) == 0;
                w = 'h6F + (rd << 7) + (((v >> 12) & 255) << 12) + (((v >> 11) & 1) << 20)
                    + (((v >> 1) & 1023) << 21) + (((v >> 20) & 1) << 31);
            end
            default: legal = 1'b0;
        endcase
        legal = legal && (!CHK || rng);
        word = w[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int a, input int d, input int s1, input int s2, input logic [31:0] im);
        req_valid = 1'b1;
        req_kind = 3'(k); req_alu = 3'(a);
        req_rd = 5'(d); req_rs1 = 5'(s1); req_rs2 = 5'(s2);
        req_imm = im;
    endtask

    task automatic do_clear();
        clear = 1'b1; req_valid = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0); req_valid = 1'b0;
        #12;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", inst); end
        tests++; if (inst_addr !== BASE) begin fails++; $display("FAIL reset_addr got %h want %h", inst_addr, BASE); end
        tests++; if (inst_count !== 16'h0) begin fails++; $display("FAIL reset_count got %h want 0", inst_count); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk); rst_n = 1'b1;
        step();
        set_req(0, 0, 3, 1, 2, 0);
        step();
        req_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL pre_async_valid got %b want 1", inst_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid got %b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL async_reset_inst got %h want 0", inst); end
        @(negedge clk); rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        do_clear();
        inst_ready = 1'b1;
        set_req(0, 0, 3, 1, 2, 0);
        step();
        tests++; if (inst !== 32'h002081B3) begin fails++; $display("FAIL add_word got %h want 002081b3", inst); end
        tests++; if (inst_addr !== BASE) begin fails++; $display("FAIL add_addr got %h want %h", inst_addr, BASE); end
        set_req(0, 1, 3, 1, 2, 0);
        step();
        tests++; if (inst !== 32'h402081B3) begin fails++; $display("FAIL sub_word got %h want 402081b3", inst); end
        tests++; if (inst_addr !== BASE + 32'd4) begin fails++; $display("FAIL sub_addr got %h want %h", inst_addr, BASE + 32'd4); end
        req_valid = 1'b0;
        step();
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL alu_drain_valid got %b want 0", inst_valid); end
        tests++; if (inst_count !== 16'd2) begin fails++; $display("FAIL alu_count got %0d want 2", inst_count); end
    endtask

    task automatic test_mem_branch();
        do_clear();
        inst_ready = 1'b1;
        set_req(2, 0, 5, 2, 0, 8);
        step();
        tests++; if (inst !== 32'h00812283) begin fails++; $display("FAIL lw_word got %h want 00812283", inst); end
        set_req(3, 0, 31, 2, 5, 12);
        step();
        tests++; if (inst !== 32'h00512623) begin fails++; $display("FAIL sw_word got %h want 00512623", inst); end
        set_req(4, 0, 31, 1, 2, -4);
        step();
        tests++; if (inst !== 32'hFE208EE3) begin fails++; $display("FAIL beq_word got %h want fe208ee3", inst); end
        set_req(5, 0, 10, 7, 9, 32'h12345000);
        step();
        tests++; if (inst !== 32'h12345537) begin fails++; $display("FAIL lui_word got %h want 12345537", inst); end
        set_req(6, 0, 1, 7, 9, 8);
        step();
        tests++; if (inst !== 32'h008000EF) begin fails++; $display("FAIL jal_word got %h want 008000ef", inst); end
        tests++; if (inst_addr !== BASE + 32'd16) begin fails++; $display("FAIL jal_addr got %h want %h", inst_addr, BASE + 32'd16); end
        req_valid = 1'b0;
        step();
        tests++; if (inst_count !== 16'd5) begin fails++; $display("FAIL mem_count got %0d want 5", inst_count); end
    endtask

    task automatic test_illegal();
        do_clear();
        inst_ready = 1'b1;
        set_req(1, 1, 4, 1, 0, 3);
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL isub_valid got %b want 0", inst_valid); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL isub_err got %b want 1", err); end
        tests++; if (inst_addr !== BASE) begin fails++; $display("FAIL isub_addr got %h want %h", inst_addr, BASE); end
        set_req(7, 0, 1, 1, 1, 0);
        step();
        set_req(0, 4, 1, 1, 1, 0);
        step();
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL kind7_alu4_valid got %b want 0", inst_valid); end
        set_req(0, 2, 1, 2, 3, 0);
        step();
        req_valid = 1'b0;
        tests++; if (inst_valid !== 1'b1 || inst_addr !== BASE) begin fails++; $display("FAIL legal_after_err got v=%b a=%h want v=1 a=%h", inst_valid, inst_addr, BASE); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
        step();
        clear = 1'b1;
        set_req(0, 0, 1, 1, 1, 0);
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL clear_ready got %b want 0", req_ready); end
        step();
        clear = 1'b0; req_valid = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL clear_err got %b want 0", err); end
        tests++; if (inst_addr !== BASE || inst_valid !== 1'b0 || inst_count !== 16'd0) begin
            fails++; $display("FAIL clear_state got a=%h v=%b c=%0d want a=%h v=0 c=0", inst_addr, inst_valid, inst_count, BASE);
        end
    endtask

    task automatic test_imm_range();
        do_clear();
        inst_ready = 1'b1;
        set_req(1, 0, 1, 0, 0, 2048);
        step();
        req_valid = 1'b0;
`ifdef RV_ENC_IMM_CHECK_EN
        tests++; if (inst_valid !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL imm2048_drop got v=%b e=%b want v=0 e=1", inst_valid, err); end
`else
        tests++; if (inst !== 32'h80000093 || err !== 1'b0) begin fails++; $display("FAIL imm2048_trunc got %h e=%b want 80000093 e=0", inst, err); end
`endif
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        bit lg;
        logic [31:0] w0;
        do_clear();
        for (int i = 0; i < 5; i++) ref_encode(0, i % 4, i + 1, i + 2, i + 3, 0, lg, w[i]);
        inst_ready = 1'b0;
        set_req(0, 0, 1, 2, 3, 0);
        step();
        w0 = inst;
        tests++; if (w0 !== w[0]) begin fails++; $display("FAIL bp_first got %h want %h", w0, w[0]); end
        set_req(0, 1, 2, 3, 4, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (req_ready !== 1'b0 || inst !== w[0] || inst_valid !== 1'b1) begin
                fails++; $display("FAIL bp_hold cyc %0d got r=%b v=%b w=%h want r=0 v=1 w=%h", c, req_ready, inst_valid, inst, w[0]);
            end
            step();
        end
        inst_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            if (i < 4) set_req(0, (i + 1) % 4, i + 2, i + 3, i + 4, 0);
            else req_valid = 1'b0;
            tests++; if (inst !== w[i] || inst_addr !== BASE + 32'(4 * i)) begin
                fails++; $display("FAIL bp_out %0d got %h@%h want %h@%h", i, inst, inst_addr, w[i], BASE + 32'(4 * i));
            end
            if (i == 4) begin
                tests++; if (inst_count !== 16'd4) begin fails++; $display("FAIL bp_count got %0d want 4", inst_count); end
                tests++; if (inst_addr !== 32'h0) begin fails++; $display("FAIL addr_wrap got %h want 0", inst_addr); end
            end
        end
        step();
        tests++; if (inst_valid !== 1'b0 || inst_addr !== 32'h4) begin fails++; $display("FAIL bp_drain got v=%b a=%h want v=0 a=4", inst_valid, inst_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] exp_addr, w, ew;
        int exp_count;
        bit exp_err, exp_rr, lg;
        int k, a;
        logic [31:0] im;
        do_clear();
        exp_addr = BASE; exp_count = 0; exp_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 7);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : int'($urandom_range(0, 4));
            if (a == 4) a = 5;
            case ($urandom_range(0, 3))
                0: im = $urandom;
                1: im = $urandom & 32'hFFFF_F000;
                default: im = 32'($urandom_range(0, 8190)) - 32'd4096;
            endcase
            set_req(k, a, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), im);
            req_valid = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 59) == 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rr = !clear && (exp_q.size() == 0 || inst_ready);
            tests++; if (req_ready !== exp_rr) begin fails++; $display("FAIL rnd_ready %0d got %b want %b", n, req_ready, exp_rr); end
            tests++; if (inst_valid !== (exp_q.size() != 0)) begin fails++; $display("FAIL rnd_valid %0d got %b want %b", n, inst_valid, exp_q.size() != 0); end
            if (clear) begin
                exp_q.delete(); exp_addr = BASE; exp_count = 0; exp_err = 1'b0;
            end else begin
                if (exp_q.size() != 0 && inst_ready) begin
                    ew = exp_q.pop_front();
                    tests++; if (inst !== ew || inst_addr !== exp_addr) begin
                        fails++; $display("FAIL rnd_word %0d got %h@%h want %h@%h", n, inst, inst_addr, ew, exp_addr);
                    end
                    exp_addr = exp_addr + 32'd4;
                    if (exp_count < 65535) exp_count++;
                end
                if (req_valid && exp_rr) begin
                    ref_encode(k, a, req_rd, req_rs1, req_rs2, im, lg, w);
                    if (lg) exp_q.push_back(w);
                    else exp_err = 1'b1;
                end
            end
            step();
            clear = 1'b0;
            tests++; if (inst_count !== 16'(exp_count) || err !== exp_err) begin
                fails++; $display("FAIL rnd_state %0d got c=%0d e=%b want c=%0d e=%b", n, inst_count, err, exp_count, exp_err);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_branch();
        test_illegal();
        test_imm_range();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
